dds_rom_scheduler: RTL and testbench
====================================

# dds_rom_scheduler

Two-channel DDS sequencer that time-shares the single 2048-entry, 48-bit coefficient ROM between two phase-accumulator channels. On each sample tick it issues one ROM address per channel, tracks the ROM read latency with a channel tag pipeline, and delivers each channel's 48-bit coefficient word with a one-cycle valid strobe. It sits between the sample-rate timing logic and the lookup-table wrapper, replacing the free-running address source.

## Interface
- PHASE_W, 32, phase accumulator and FTW width
- ADDR_W, 11, ROM address width; address = phase[PHASE_W-1 -: ADDR_W]
- DATA_W, 48, ROM word width
- ROM_LAT, 2, cycles from rom_ad valid to rom_data valid (ce + oce registers)

Ports:
- Fg_CLK  in  1  system clock; all logic on rising edge
- RESETn  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle pulse requesting one sample per channel
- ftw0, ftw1  in  PHASE_W  frequency tuning words, channel 0/1
- ftw_load  in  1  capture ftw0/ftw1 into shadow registers
- phase_clr  in  1  zero both phase accumulators
- rom_ad  out  ADDR_W  ROM address, registered
- rom_ce  out  1  ROM clock enable
- rom_data  in  DATA_W  ROM output word
- ch0_data, ch1_data  out  DATA_W  latched coefficient per channel
- ch0_valid, ch1_valid  out  1  one-cycle strobe, new chN_data
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; a tick arrived while busy

## Operation
- Reset (async): phases, shadow and active FTWs = 0; rom_ad = 0; rom_ce, busy, overrun, valids = 0; chN_data = 0; tag pipeline cleared; state IDLE. Reset mid-sample discards all in-flight reads; no valid pulses follow.
- FSM: IDLE -> ISSUE0 (tick accepted) -> ISSUE1 -> DRAIN (ROM_LAT+1 cycles, down-counter) -> IDLE.
- Tick in IDLE: accepted; active FTWs <= shadow FTWs; rom_ad <= phase0 top ADDR_W bits.
- ISSUE0 -> ISSUE1 edge: rom_ad <= phase1 top bits.
- ISSUE1 -> DRAIN edge: phaseN <= phaseN + ftw_activeN, modulo 2^PHASE_W (natural wrap, no saturation).
- Tick while state != IDLE: dropped, overrun <= 1 (sticky until reset).
- ftw_load: shadow <= ftw0/ftw1 on that edge, any state; takes effect at the next accepted tick only. ftw_load coincident with accepted tick: active takes the old shadow value.
- phase_clr: both phases <= 0 on that edge, any state; overrides a coincident increment. Addresses already issued are unaffected.
- Tag pipeline: ROM_LAT+1-deep shift of {valid, ch}; entry pushed when rom_ad is loaded. On emergence, chN_data <= rom_data, chN_valid = 1 for one cycle.
- rom_ce = 1 in ISSUE0, ISSUE1, DRAIN; 0 in IDLE.
- First sample after reset: both channels read address 0.

## Timing
- Tick in cycle T (IDLE): rom_ad = ch0 address in T+1, ch1 address in T+2.
- rom_data for ch0 valid in T+1+ROM_LAT, for ch1 in T+2+ROM_LAT.
- ch0_valid in T+2+ROM_LAT (T+4), ch1_valid in T+3+ROM_LAT (T+5); registered outputs.
- busy high T+1 through T+3+ROM_LAT; IDLE at T+4+ROM_LAT, so minimum accepted tick period = ROM_LAT+4 (6) cycles.
- chN_data holds until next valid strobe for that channel.

## Structure
- Shared package dds_pkg: PHASE_W, ADDR_W, DATA_W, ROM_LAT defaults; FSM state enum (IDLE, ISSUE0, ISSUE1, DRAIN).
- Sub-module dds_phase_acc (phase register, shadow/active FTW, clear/advance), instantiated once per channel.
- Tag pipeline and FSM stay in the top block; ROM wrapper instantiated outside.

## Test plan
- Reset: all outputs 0; ticks every 6 cycles with ftw0 = 0x0020_0000 loaded -> ch0 addresses 0,1,2,3; ch0_valid at T+4 each time.
- ftw1 = 0x4000_0000 -> ch1 addresses 0,512,1024,1536,0 (wrap); ch1_valid at T+5; behavioural ROM model data matches per address.
- Tick at T and T+3 -> second tick dropped, overrun = 1 and stays 1; only one valid pair.
- ftw_load with new ftw0 = 0x0040_0000 mid-DRAIN -> current sample's increment unchanged; step becomes 2 from the following sample.
- phase_clr coincident with ISSUE1 -> DRAIN edge -> next sample addresses both 0.
- RESETn asserted at T+2 -> no ch0/ch1_valid pulses; state IDLE; next tick reads address 0.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared parameters, FSM state encoding and ROM read tag type for the two-channel DDS ROM sequencer.
package dds_pkg;

  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 48;
  localparam int ROM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE0,
    ISSUE1,
    DRAIN
  } dds_state_t;

  typedef struct packed {
    logic valid;
    logic ch;
  } rom_tag_t;

endpackage

// File: rtl/dds_phase_acc.sv
// One DDS channel: phase accumulator with a shadow FTW that only becomes active on an accepted sample tick.
module dds_phase_acc #(
  parameter int PHASE_W = dds_pkg::PHASE_W,
  parameter int ADDR_W  = dds_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic               accept,
  input  logic               advance,
  input  logic               clear,
  output logic [ADDR_W-1:0]  addr
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] ftw_shadow;
  logic [PHASE_W-1:0] ftw_active;

  // Active FTW samples the shadow before a coincident load updates it, so a new word waits one sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      ftw_shadow <= '0;
      ftw_active <= '0;
    end else begin
      if (ftw_load) ftw_shadow <= ftw;
      if (accept)   ftw_active <= ftw_shadow;
      if (clear)        phase <= '0;
      else if (advance) phase <= phase + ftw_active;
    end
  end

  assign addr = phase[PHASE_W-1 -: ADDR_W];

endmodule

// File: rtl/dds_rom_scheduler.sv
// Two-channel DDS sequencer sharing one coefficient ROM: issues ch0 then ch1 addresses per sample tick
// and tags each read so the returning word is steered to the right channel after the ROM latency.
module dds_rom_scheduler #(
  parameter int PHASE_W = dds_pkg::PHASE_W,
  parameter int ADDR_W  = dds_pkg::ADDR_W,
  parameter int DATA_W  = dds_pkg::DATA_W,
  parameter int ROM_LAT = dds_pkg::ROM_LAT
) (
  input  logic               Fg_CLK,
  input  logic               RESETn,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] ftw0,
  input  logic [PHASE_W-1:0] ftw1,
  input  logic               ftw_load,
  input  logic               phase_clr,
  output logic [ADDR_W-1:0]  rom_ad,
  output logic               rom_ce,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  ch0_data,
  output logic [DATA_W-1:0]  ch1_data,
  output logic               ch0_valid,
  output logic               ch1_valid,
  output logic               busy,
  output logic               overrun
);

  import dds_pkg::*;

  localparam int CNT_W = $clog2(ROM_LAT + 1);

  dds_state_t        state;
  logic [CNT_W-1:0]  drain_cnt;
  rom_tag_t          tag_pipe [0:ROM_LAT];
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              accept;
  logic              advance;

  assign accept  = sample_tick && (state == IDLE);
  assign advance = (state == ISSUE1);
  assign busy    = (state != IDLE);
  assign rom_ce  = (state != IDLE);

  dds_phase_acc #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) u_phase0 (
    .clk      (Fg_CLK),
    .rst_n    (RESETn),
    .ftw      (ftw0),
    .ftw_load (ftw_load),
    .accept   (accept),
    .advance  (advance),
    .clear    (phase_clr),
    .addr     (addr0)
  );

  dds_phase_acc #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) u_phase1 (
    .clk      (Fg_CLK),
    .rst_n    (RESETn),
    .ftw      (ftw1),
    .ftw_load (ftw_load),
    .accept   (accept),
    .advance  (advance),
    .clear    (phase_clr),
    .addr     (addr1)
  );

  // The tag is pushed in the same edge that loads rom_ad, so it reaches the last stage exactly when rom_data is valid.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      drain_cnt <= '0;
      rom_ad    <= '0;
      overrun   <= 1'b0;
      ch0_valid <= 1'b0;
      ch1_valid <= 1'b0;
      ch0_data  <= '0;
      ch1_data  <= '0;
      for (int i = 0; i <= ROM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      ch0_valid   <= 1'b0;
      ch1_valid   <= 1'b0;
      tag_pipe[0] <= '0;
      for (int i = 1; i <= ROM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      if (tag_pipe[ROM_LAT].valid) begin
        if (tag_pipe[ROM_LAT].ch) begin
          ch1_data  <= rom_data;
          ch1_valid <= 1'b1;
        end else begin
          ch0_data  <= rom_data;
          ch0_valid <= 1'b1;
        end
      end

      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state       <= ISSUE0;
            rom_ad      <= addr0;
            tag_pipe[0] <= '{valid: 1'b1, ch: 1'b0};
          end
        end
        ISSUE0: begin
          state       <= ISSUE1;
          rom_ad      <= addr1;
          tag_pipe[0] <= '{valid: 1'b1, ch: 1'b1};
        end
        ISSUE1: begin
          state     <= DRAIN;
          drain_cnt <= CNT_W'(ROM_LAT);
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= IDLE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_rom_scheduler.sv
// Randomized scoreboard bench for dds_rom_scheduler with a cycle-level reference model and a behavioural ROM.
module tb_dds_rom_scheduler;

  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 48;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic               Fg_CLK = 1'b0;
  logic               RESETn;
  logic               sample_tick;
  logic [PHASE_W-1:0] ftw0, ftw1;
  logic               ftw_load, phase_clr;
  logic [ADDR_W-1:0]  rom_ad;
  logic               rom_ce;
  logic [DATA_W-1:0]  rom_data;
  logic [DATA_W-1:0]  ch0_data, ch1_data;
  logic               ch0_valid, ch1_valid, busy, overrun;

  logic [DATA_W-1:0]  rom_r1, rom_r2;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // Reference model state
  logic [PHASE_W-1:0] ph0, ph1, sh0, sh1, act0, act1;
  logic [DATA_W-1:0]  last0, last1;
  bit                 have_acc;
  int                 last_t, ov_cyc;
  exp_t               q0[$];
  exp_t               q1[$];

  dds_rom_scheduler dut (
    .Fg_CLK      (Fg_CLK),
    .RESETn      (RESETn),
    .sample_tick (sample_tick),
    .ftw0        (ftw0),
    .ftw1        (ftw1),
    .ftw_load    (ftw_load),
    .phase_clr   (phase_clr),
    .rom_ad      (rom_ad),
    .rom_ce      (rom_ce),
    .rom_data    (rom_data),
    .ch0_data    (ch0_data),
    .ch1_data    (ch1_data),
    .ch0_valid   (ch0_valid),
    .ch1_valid   (ch1_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  always @(posedge Fg_CLK) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {a, 5'h15, a ^ 11'h2A5, 10'h3C3, a[7:0], a[2:0] ^ 3'b101};
  endfunction

  // Two-register ROM model: address seen in cycle N gives data in cycle N+2.
  always @(posedge Fg_CLK) begin
    rom_r1 <= rom_word(rom_ad);
    rom_r2 <= rom_r1;
  end
  assign rom_data = rom_r2;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  function automatic logic [ADDR_W-1:0] top_addr(input logic [PHASE_W-1:0] p);
    return ADDR_W'(p >> (PHASE_W - ADDR_W));
  endfunction

  task automatic modelClear();
    ph0 = '0; ph1 = '0; sh0 = '0; sh1 = '0; act0 = '0; act1 = '0;
    last0 = '0; last1 = '0;
    have_acc = 1'b0; last_t = -100; ov_cyc = -1;
    q0.delete(); q1.delete();
  endtask

  // One cycle of stimulus; the model predicts what the next rising edge does.
  task automatic applyStimulus(input logic tk, input logic ld, input logic [PHASE_W-1:0] f0,
                               input logic [PHASE_W-1:0] f1, input logic clr);
    int  c;
    bit  busy_now;
    @(posedge Fg_CLK); #1;
    sample_tick = tk; ftw_load = ld; ftw0 = f0; ftw1 = f1; phase_clr = clr;
    c = cyc;
    busy_now = have_acc && (c >= last_t + 1) && (c <= last_t + 5);
    if (tk && busy_now && ov_cyc < 0) ov_cyc = c + 1;
    if (tk && !busy_now) begin
      have_acc = 1'b1;
      last_t   = c;
      act0 = sh0; act1 = sh1;
      q0.push_back('{data: rom_word(top_addr(ph0)), cyc: c + 4});
    end else if (have_acc && c == last_t + 1) begin
      q1.push_back('{data: rom_word(top_addr(ph1)), cyc: c + 4});
    end
    if (ld) begin sh0 = f0; sh1 = f1; end
    if (clr) begin
      ph0 = '0; ph1 = '0;
    end else if (have_acc && c == last_t + 2) begin
      ph0 = ph0 + act0; ph1 = ph1 + act1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic applyReset(input int n);
    @(posedge Fg_CLK); #1;
    RESETn = 1'b0;
    sample_tick = 1'b0; ftw_load = 1'b0; phase_clr = 1'b0; ftw0 = '0; ftw1 = '0;
    modelClear();
    #1;
    checkOutput("reset_rom_ad", rom_ad, '0);
    checkOutput("reset_valids", {ch0_valid, ch1_valid}, '0);
    repeat (n) @(posedge Fg_CLK);
    #1;
    RESETn = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a valid is due and checks status outputs every cycle.
  logic e0, e1, exp_busy, exp_ov;
  always @(negedge Fg_CLK) begin
    exp_busy = have_acc && (cyc >= last_t + 1) && (cyc <= last_t + 5);
    exp_ov   = (ov_cyc >= 0) && (cyc >= ov_cyc);
    checkOutput("busy", busy, exp_busy);
    checkOutput("rom_ce", rom_ce, exp_busy);
    checkOutput("overrun", overrun, exp_ov);
    e0 = (q0.size() > 0) && (q0[0].cyc == cyc);
    e1 = (q1.size() > 0) && (q1[0].cyc == cyc);
    checkOutput("ch0_valid", ch0_valid, e0);
    checkOutput("ch1_valid", ch1_valid, e1);
    if (e0) begin last0 = q0[0].data; void'(q0.pop_front()); end
    if (e1) begin last1 = q1[0].data; void'(q1.pop_front()); end
    checkOutput("ch0_data", ch0_data, last0);
    checkOutput("ch1_data", ch1_data, last1);
  end

  initial begin
    RESETn = 1'b0;
    sample_tick = 1'b0; ftw_load = 1'b0; phase_clr = 1'b0; ftw0 = '0; ftw1 = '0;
    modelClear();
    repeat (3) @(posedge Fg_CLK);
    #1;
    checkOutput("reset_rom_ad", rom_ad, '0);
    checkOutput("reset_rom_ce", rom_ce, '0);
    RESETn = 1'b1;

    $display("[TB] stepping ch0 by one address and ch1 by a quarter turn");
    applyStimulus(1'b0, 1'b1, 32'h0020_0000, 32'h4000_0000, 1'b0);
    repeat (5) begin
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
      idle(5);
    end

    $display("[TB] tick while busy");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    idle(6);

    $display("[TB] ftw_load during drain");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 32'h0040_0000, 32'h4000_0000, 1'b0);
    idle(2);
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
      idle(5);
    end

    $display("[TB] phase_clr on the advance edge");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    idle(3);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    idle(5);

    $display("[TB] reset in the middle of a sample");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    idle(1);
    applyReset(2);
    idle(2);
    applyStimulus(1'b0, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    idle(6);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) applyReset($urandom_range(1, 3));
      else applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                         $urandom, $urandom, ($urandom_range(0, 19) == 0));
    end

    idle(12);
    checkOutput("ch0_pending", q0.size(), 0);
    checkOutput("ch1_pending", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
